// File: rtl/cmac_csb_reg_file.sv
// cmac_csb_reg_file: CSB register file for CMAC_A with ping-pong D_* groups and S_* status/pointer registers
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, asynchronous active-low reset
//   csb2cmac_a_req_pvld/prdy/pd        CSB request (prdy tied high)
//   cmac_a2csb_resp_valid/pd           registered read / non-posted write response
//   dp2reg_done                        datapath done pulse, retires the consumer group
//   reg2dp_op_en/conv_mode/proc_precision  consumer group fields to the datapath
//   slcg_op_en                         registered clock-gating enables
module cmac_csb_reg_file #(
  parameter int SLCG_NUM = 3
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                csb2cmac_a_req_pvld,
  output logic                csb2cmac_a_req_prdy,
  input  logic [62:0]         csb2cmac_a_req_pd,
  output logic                cmac_a2csb_resp_valid,
  output logic [33:0]         cmac_a2csb_resp_pd,
  input  logic                dp2reg_done,
  output logic                reg2dp_op_en,
  output logic                reg2dp_conv_mode,
  output logic [1:0]          reg2dp_proc_precision,
  output logic [SLCG_NUM-1:0] slcg_op_en
);
  logic [9:0]  addr;
  logic [31:0] wdat;
  logic        write, nposted, wr_en, unused_ok;
  logic [1:0]       op_en_q, op_en_d, conv_q, conv_d;
  logic [1:0][1:0]  prec_q, prec_d;
  logic             producer_q, producer_d, consumer_q, consumer_d;
  logic             resp_valid_q, resp_valid_d;
  logic [33:0]      resp_pd_q, resp_pd_d;
  logic [SLCG_NUM-1:0] slcg_q;
  logic [1:0]  st0, st1;
  logic [31:0] rdat;
  assign addr      = csb2cmac_a_req_pd[9:0];
  assign wdat      = csb2cmac_a_req_pd[53:22];
  assign write     = csb2cmac_a_req_pd[54];
  assign nposted   = csb2cmac_a_req_pd[55];
  assign unused_ok = ^{csb2cmac_a_req_pd[62:56], csb2cmac_a_req_pd[21:10]};
  assign wr_en     = csb2cmac_a_req_pvld & write;
  assign csb2cmac_a_req_prdy = 1'b1;
  // Running when the group is the one the datapath consumes, otherwise queued.
  assign st0 = op_en_q[0] ? (consumer_q == 1'b0 ? 2'd1 : 2'd2) : 2'd0;
  assign st1 = op_en_q[1] ? (consumer_q == 1'b1 ? 2'd1 : 2'd2) : 2'd0;
  always_comb begin
    rdat = addr == 10'h000 ? {14'b0, st1, 14'b0, st0} :
           addr == 10'h001 ? {15'b0, consumer_q, 15'b0, producer_q} :
           addr == 10'h002 ? {31'b0, op_en_q[producer_q]} :
           addr == 10'h003 ? {18'b0, prec_q[producer_q], 11'b0, conv_q[producer_q]} : 32'h0;
  end
  always_comb begin
    op_en_d    = op_en_q;
    conv_d     = conv_q;
    prec_d     = prec_q;
    producer_d = producer_q;
    consumer_d = consumer_q;
    if (wr_en && addr == 10'h001) producer_d = wdat[0];
    if (wr_en && addr == 10'h002) op_en_d[producer_q] = wdat[0];
    if (wr_en && addr == 10'h003) begin
      conv_d[producer_q] = wdat[0];
      prec_d[producer_q] = wdat[13:12];
    end
    // Applied after the CSB write so a colliding op_en write loses to done.
    if (dp2reg_done) begin
      op_en_d[consumer_q] = 1'b0;
      consumer_d          = ~consumer_q;
    end
  end
  always_comb begin
    resp_valid_d = csb2cmac_a_req_pvld & (~write | nposted);
    resp_pd_d    = resp_valid_d ? {write, 1'b0, write ? 32'h0 : rdat} : resp_pd_q;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_q      <= '0;
      conv_q       <= '0;
      prec_q       <= '0;
      producer_q   <= 1'b0;
      consumer_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= '0;
      slcg_q       <= '0;
    end else begin
      op_en_q      <= op_en_d;
      conv_q       <= conv_d;
      prec_q       <= prec_d;
      producer_q   <= producer_d;
      consumer_q   <= consumer_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
      slcg_q       <= {SLCG_NUM{reg2dp_op_en}};
    end
  end
  assign reg2dp_op_en          = op_en_q[consumer_q];
  assign reg2dp_conv_mode      = conv_q[consumer_q];
  assign reg2dp_proc_precision = prec_q[consumer_q];
  assign cmac_a2csb_resp_valid = resp_valid_q;
  assign cmac_a2csb_resp_pd    = resp_pd_q;
  assign slcg_op_en            = slcg_q;
endmodule

// File: tb/tb_cmac_csb_reg_file.sv
// tb_cmac_csb_reg_file: directed self-checking bench for cmac_csb_reg_file
module tb_cmac_csb_reg_file;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pvld = 1'b0;
  logic        prdy;
  logic [62:0] pd = '0;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic        done = 1'b0;
  logic        op_en, conv_mode;
  logic [1:0]  prec;
  logic [2:0]  slcg;
  int n_checks = 0;
  int n_fail = 0;
  cmac_csb_reg_file #(.SLCG_NUM(3)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .csb2cmac_a_req_pvld(pvld), .csb2cmac_a_req_prdy(prdy), .csb2cmac_a_req_pd(pd),
    .cmac_a2csb_resp_valid(resp_valid), .cmac_a2csb_resp_pd(resp_pd),
    .dp2reg_done(done), .reg2dp_op_en(op_en), .reg2dp_conv_mode(conv_mode),
    .reg2dp_proc_precision(prec), .slcg_op_en(slcg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [23:0] boff, input logic [31:0] d, input logic wr, input logic np, input logic dn);
    @(negedge clk);
    pvld = 1'b1;
    pd = '0;
    pd[21:0] = boff[23:2];
    pd[53:22] = d;
    pd[54] = wr;
    pd[55] = np;
    pd[60:57] = 4'hf;
    done = dn;
    @(negedge clk);
    pvld = 1'b0;
    pd = '0;
    done = 1'b0;
  endtask
  task automatic rd(input logic [23:0] boff, input logic [31:0] exp);
    req(boff, 32'h0, 1'b0, 1'b0, 1'b0);
    check($sformatf("rd_valid_%h", boff), 64'(resp_valid), 64'd1);
    check($sformatf("rd_pd_%h", boff), 64'(resp_pd), 64'({2'b00, exp}));
  endtask
  task automatic wr(input logic [23:0] boff, input logic [31:0] d, input logic np);
    req(boff, d, 1'b1, np, 1'b0);
    check($sformatf("wr_valid_%h", boff), 64'(resp_valid), 64'(np));
    if (np) check($sformatf("wr_pd_%h", boff), 64'(resp_pd), 64'h2_0000_0000);
  endtask
  task automatic pulse_done;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_slcg", 64'(slcg), 64'd0);
    check("prdy", 64'(prdy), 64'd1);
    rstn = 1'b1;
    rd(24'h000, 32'h0);
    rd(24'h004, 32'h0);
    rd(24'h008, 32'h0);
    rd(24'h00c, 32'h0);
    wr(24'h00c, 32'h3001, 1'b1);
    rd(24'h00c, 32'h0000_3001);
    check("conv_mode_g0", 64'(conv_mode), 64'd1);
    check("prec_g0", 64'(prec), 64'd3);
    wr(24'h008, 32'h1, 1'b0);
    check("op_en_set", 64'(op_en), 64'd1);
    check("slcg_delay", 64'(slcg), 64'd0);
    @(negedge clk);
    check("slcg_on", 64'(slcg), 64'h7);
    rd(24'h000, 32'h0000_0001);
    pulse_done;
    check("op_en_done", 64'(op_en), 64'd0);
    rd(24'h004, 32'h0001_0000);
    rd(24'h000, 32'h0);
    pulse_done;
    rd(24'h004, 32'h0);
    wr(24'h008, 32'h1, 1'b1);
    wr(24'h004, 32'h1, 1'b1);
    wr(24'h00c, 32'h1, 1'b1);
    wr(24'h008, 32'h1, 1'b0);
    rd(24'h000, 32'h0002_0001);
    check("conv_g0_active", 64'(conv_mode), 64'd1);
    check("prec_g0_active", 64'(prec), 64'd3);
    pulse_done;
    rd(24'h004, 32'h0001_0001);
    check("op_en_g1", 64'(op_en), 64'd1);
    check("conv_g1", 64'(conv_mode), 64'd1);
    check("prec_g1", 64'(prec), 64'd0);
    rd(24'h000, 32'h0001_0000);
    rd(24'h100c, 32'h0000_0001);
    req(24'h008, 32'h1, 1'b1, 1'b1, 1'b1);
    check("collide_resp", 64'(resp_pd), 64'h2_0000_0000);
    rd(24'h000, 32'h0);
    rd(24'h004, 32'h0000_0001);
    rd(24'h3fc, 32'h0);
    wr(24'h3fc, 32'hffff_ffff, 1'b1);
    rd(24'h00c, 32'h0000_0001);
    wr(24'h008, 32'h1, 1'b0);
    check("posted_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    pvld = 1'b1;
    pd = '0;
    @(negedge clk);
    pvld = 1'b0;
    check("inflight_valid", 64'(resp_valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_drop_valid", 64'(resp_valid), 64'd0);
    check("rst_drop_pd", 64'(resp_pd), 64'd0);
    check("rst_op_en", 64'(op_en), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd(24'h000, 32'h0);
    rd(24'h004, 32'h0);
    rd(24'h008, 32'h0);
    rd(24'h00c, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmac_csb_reg_file.md
Name: cmac_csb_reg_file

Overview:
CSB-facing configuration register file for the convolution MAC (CMAC_A) unit. It decodes CSB read/write requests, holds two ping-pong register groups (D_*) plus single-copy status/pointer registers (S_*), and drives the active group's fields to the MAC datapath. It returns read and non-posted-write responses, tracks group status, and retires the active group on the datapath's done pulse.

Parameters:
SLCG_NUM, 3, width of slcg_op_en (one bit per clock-gating domain)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  reset, asynchronous, active-low
csb2cmac_a_req_pvld  in  1  request valid
csb2cmac_a_req_prdy  out  1  request ready
csb2cmac_a_req_pd  in  63  request payload
cmac_a2csb_resp_valid  out  1  response valid (one-cycle pulse)
cmac_a2csb_resp_pd  out  34  response payload
dp2reg_done  in  1  datapath finished current layer (one-cycle pulse)
reg2dp_op_en  out  1  op_en of consumer group
reg2dp_conv_mode  out  1  conv_mode of consumer group (0 direct, 1 winograd)
reg2dp_proc_precision  out  2  proc_precision of consumer group
slcg_op_en  out  SLCG_NUM  clock-gating enables

Behaviour:
- Clocking: single clock nvdla_core_clk; reset nvdla_core_rstn is asynchronous, active-low.
- Request fields: addr=pd[21:0] (word address), wdat=pd[53:22], write=pd[54], nposted=pd[55], srcpriv=pd[56], wrbe=pd[60:57], level=pd[62:61].
  - Only addr[9:0] is decoded. Byte offset is {addr[9:0],2'b00}. wrbe is ignored: writes are full-word.
- csb2cmac_a_req_prdy is tied to 1. A request is accepted when pvld=1.
- Register map (byte offset):
  - 0x000 S_STATUS (RO): [1:0] status_0, [17:16] status_1. Encoding: 0 idle, 1 running, 2 pending.
  - 0x004 S_POINTER: [0] producer (RW), [16] consumer (RO).
  - 0x008 D_OP_ENABLE: [0] op_en (RW, targets producer group).
  - 0x00c D_MISC_CFG: [0] conv_mode, [13:12] proc_precision (RW, producer group).
  - Unlisted bits read 0. Unmapped offsets read 0; writes to them are ignored.
- Reads of D_* registers return the producer group's contents.
- Response timing: registered, valid one cycle after acceptance.
  - Read: resp_pd={1'b0, error=0, rdat[31:0]}.
  - Write with nposted=1: resp_pd={1'b1, error=0, 32'h0}.
  - Posted write: no response.
- Group state:
  - Writing op_en=1 to group G sets G.op_en.
  - status_G = running(1) if G.op_en and G==consumer; pending(2) if G.op_en and G!=consumer; else idle(0).
- dp2reg_done pulse: clears the consumer group's op_en and toggles consumer, both in the same cycle. If a CSB write hits that group's op_en in the same cycle, done wins.
- Datapath outputs:
  - reg2dp_* are muxed combinationally from the consumer group.
  - slcg_op_en = {SLCG_NUM{reg2dp_op_en}}, registered (one-cycle delay).
- Reset values: all group fields 0, producer=0, consumer=0, resp_valid=0, resp_pd=0, slcg_op_en=0.
- Reset asserted mid-operation clears all state immediately. A response in flight is dropped.

Test Plan:
- Reset then read 0x000, 0x004, 0x008, 0x00c -> each response pd=34'h0_0000_0000, one cycle after its request.
- Write 0x00c wdat=0x3001 nposted=1, then read 0x00c -> write resp pd=34'h2_0000_0000; read returns 0x00003001. reg2dp_conv_mode=1, proc_precision=3 (consumer=producer=0).
- Write D_OP_ENABLE=1 -> reg2dp_op_en=1 next cycle, S_STATUS=0x00000001, slcg_op_en=3'b111 one cycle later. Pulse dp2reg_done -> op_en=0, S_POINTER=0x00010000, status=0.
- Program group0 op_en; set producer=1 (write 0x004=1); write group1 conv_mode=1, op_en=1 -> S_STATUS=0x00020001. After done: consumer=1, reg2dp_conv_mode=1, S_STATUS=0x00010000.
- Posted write (nposted=0) to 0x008 -> no resp_valid. Read of unmapped 0x3fc -> rdat 0, error 0.
- Assert reset while resp_valid is pending -> resp_valid=0 and all registers read 0 after release.
